// File: rtl/conv_window_sequencer_if.sv
// Purpose: bundles the sequencer's control, pixel-read and result-tag signals.
// Latency: none, wiring only.
// Backpressure: stall travels from the consumer side into the sequencer.
interface conv_window_sequencer_if #(
    parameter int IMAGE_SIZE = 28
);
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE * IMAGE_SIZE) : 1;

    logic          start;
    logic          stall;
    logic          busy;
    logic          pix_req;
    logic [AW-1:0] pix_addr;
    logic          enable;
    logic          out_valid;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          done;

    // Sequencer side.
    modport master (
        input  start, stall,
        output busy, pix_req, pix_addr, enable, out_valid, out_row, out_col, done
    );

    // Environment side: image buffer, convolver and frame controller.
    modport slave (
        output start, stall,
        input  busy, pix_req, pix_addr, enable, out_valid, out_row, out_col, done
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Purpose: raster-walks one image frame, issues pixel reads and window enables, tags convolver results.
// Latency: first read one cycle after start; out_valid trails enable by PIPE_LATENCY cycles.
// Backpressure: stall freezes pixel issue in RUN only; the result pipeline keeps shifting.
module conv_window_sequencer #(
    parameter int KERNEL_SIZE  = 5,
    parameter int IMAGE_SIZE   = 28,
    parameter int PIPE_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_window_sequencer_if.master  bus
);
    localparam int CW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int AW = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE * IMAGE_SIZE) : 1;
    localparam int DW = $clog2(PIPE_LATENCY + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_SIZE - 1);
    localparam logic [CW-1:0] WIN_OFS  = CW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // One in-flight convolver result: valid flag plus window top-left corner.
    typedef struct packed {
        logic          vld;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
    } tag_t;

    state_t        state, state_nxt;
    logic [CW-1:0] row, col;
    logic [DW-1:0] drain_cnt;
    tag_t          pipe [PIPE_LATENCY];
    tag_t          pipe_in;

    logic issue;
    logic last_pix;
    logic win_ok;

    assign issue    = (state == RUN) && !bus.stall;
    assign last_pix = (row == LAST_IDX) && (col == LAST_IDX);
    assign win_ok   = (row >= WIN_OFS) && (col >= WIN_OFS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode: start only matters in IDLE, stall only gates progress in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)          state_nxt = RUN;
            RUN:     if (issue && last_pix)  state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster counters advance on each issued pixel and wrap to 0 after the last one; drain counter runs only in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
        end else begin
            if (issue) begin
                if (col == LAST_IDX) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
        end
    end

    // Tag entering the result pipeline; coordinates are only formed when the window is valid.
    always_comb begin
        pipe_in     = '0;
        pipe_in.vld = issue && win_ok;
        if (issue && win_ok) begin
            pipe_in.row = row - WIN_OFS;
            pipe_in.col = col - WIN_OFS;
        end
    end

    // Free-running result pipeline mirroring the convolver latency; reset drops in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= pipe_in;
            for (int i = 1; i < PIPE_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Output decode from registered state; stall gates pix_req and enable combinationally.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.pix_req   = issue;
        bus.pix_addr  = issue ? (AW'(row) * AW'(IMAGE_SIZE) + AW'(col)) : '0;
        bus.enable    = issue && win_ok;
        bus.out_valid = pipe[PIPE_LATENCY-1].vld;
        bus.out_row   = pipe[PIPE_LATENCY-1].vld ? pipe[PIPE_LATENCY-1].row : '0;
        bus.out_col   = pipe[PIPE_LATENCY-1].vld ? pipe[PIPE_LATENCY-1].col : '0;
        bus.done      = (state == DONE);
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Purpose: checks a default (28/5/2) and a minimal (4/4/1) sequencer against a frame-schedule model.
// Latency: both instances share start/stall/rst; every output is compared every cycle.
// Backpressure: stall is driven directed and randomly to exercise the RUN freeze.
module tb_conv_window_sequencer;
    logic clk = 1'b0;
    logic rst, start, stall;

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.IMAGE_SIZE(28)) bus0();
    conv_window_sequencer_if #(.IMAGE_SIZE(4))  bus1();

    assign bus0.start = start;
    assign bus0.stall = stall;
    assign bus1.start = start;
    assign bus1.stall = stall;

    conv_window_sequencer #(.KERNEL_SIZE(5), .IMAGE_SIZE(28), .PIPE_LATENCY(2))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv_window_sequencer #(.KERNEL_SIZE(4), .IMAGE_SIZE(4), .PIPE_LATENCY(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int img_n [2] = '{28, 4};
    int ker_k [2] = '{5, 4};
    int lat   [2] = '{2, 1};

    // Reference model: a frame is a list of pixels issued one per unstalled cycle;
    // each window-closing pixel schedules a tagged result lat cycles later,
    // and done lands lat+1 cycles after the last pixel.
    bit m_run  [2] = '{1'b0, 1'b0};
    int m_pix  [2] = '{0, 0};
    int m_done [2] = '{-1, -1};
    int exp_out [int];

    // Tallies of what DUT0 / DUT1 actually produced.
    int cnt_req, cnt_en, cnt_ov, cnt_done;
    int first_en_cyc, first_en_addr, first_ov_cyc, first_ov_rc;
    int last_ov_cyc, last_ov_rc, done_cyc;
    int d1_en_cnt, d1_en_cyc, d1_en_addr, d1_ov_cyc, d1_ov_rc, d1_done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_tallies();
        cnt_req = 0; cnt_en = 0; cnt_ov = 0; cnt_done = 0;
        first_en_cyc = -1; first_en_addr = -1; first_ov_cyc = -1; first_ov_rc = -1;
        last_ov_cyc = -1; last_ov_rc = -1; done_cyc = -1;
        d1_en_cnt = 0; d1_en_cyc = -1; d1_en_addr = -1; d1_ov_cyc = -1; d1_ov_rc = -1; d1_done_cyc = -1;
    endtask

    task automatic run_cycle(input logic r, input logic s, input logic st);
        logic [31:0] o_req, o_addr, o_en, o_ov, o_row, o_col, o_done, o_busy;
        int n, k, pr, pc, key, e_addr, e_row, e_col;
        logic e_req, e_en, e_ov, e_done, e_busy;
        rst = r; start = s; stall = st;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                o_req = 32'(bus0.pix_req); o_addr = 32'(bus0.pix_addr); o_en = 32'(bus0.enable);
                o_ov = 32'(bus0.out_valid); o_row = 32'(bus0.out_row); o_col = 32'(bus0.out_col);
                o_done = 32'(bus0.done); o_busy = 32'(bus0.busy);
            end else begin
                o_req = 32'(bus1.pix_req); o_addr = 32'(bus1.pix_addr); o_en = 32'(bus1.enable);
                o_ov = 32'(bus1.out_valid); o_row = 32'(bus1.out_row); o_col = 32'(bus1.out_col);
                o_done = 32'(bus1.done); o_busy = 32'(bus1.busy);
            end
            n = img_n[d]; k = ker_k[d];
            pr = m_pix[d] / n;
            pc = m_pix[d] % n;
            e_req  = m_run[d] && !st;
            e_addr = e_req ? m_pix[d] : 0;
            e_en   = e_req && (pr >= k - 1) && (pc >= k - 1);
            key    = d * 1000000 + cyc;
            e_ov   = exp_out.exists(key);
            e_row  = e_ov ? exp_out[key] / 256 : 0;
            e_col  = e_ov ? exp_out[key] % 256 : 0;
            e_done = (cyc == m_done[d]);
            e_busy = m_run[d] || (m_done[d] >= cyc);

            check($sformatf("d%0d pix_req", d),   o_req,  32'(e_req));
            check($sformatf("d%0d pix_addr", d),  o_addr, 32'(e_addr));
            check($sformatf("d%0d enable", d),    o_en,   32'(e_en));
            check($sformatf("d%0d out_valid", d), o_ov,   32'(e_ov));
            check($sformatf("d%0d out_row", d),   o_row,  32'(e_row));
            check($sformatf("d%0d out_col", d),   o_col,  32'(e_col));
            check($sformatf("d%0d done", d),      o_done, 32'(e_done));
            check($sformatf("d%0d busy", d),      o_busy, 32'(e_busy));

            if (d == 0) begin
                if (o_req == 1) cnt_req++;
                if (o_en == 1) begin
                    cnt_en++;
                    if (first_en_cyc < 0) begin first_en_cyc = cyc; first_en_addr = int'(o_addr); end
                end
                if (o_ov == 1) begin
                    cnt_ov++;
                    if (first_ov_cyc < 0) begin first_ov_cyc = cyc; first_ov_rc = int'(o_row * 256 + o_col); end
                    last_ov_cyc = cyc;
                    last_ov_rc  = int'(o_row * 256 + o_col);
                end
                if (o_done == 1) begin cnt_done++; done_cyc = cyc; end
            end else begin
                if (o_en == 1) begin d1_en_cnt++; d1_en_cyc = cyc; d1_en_addr = int'(o_addr); end
                if (o_ov == 1) begin d1_ov_cyc = cyc; d1_ov_rc = int'(o_row * 256 + o_col); end
                if (o_done == 1) d1_done_cyc = cyc;
            end

            if (r) begin
                m_run[d] = 1'b0; m_pix[d] = 0; m_done[d] = -1;
            end else begin
                if (e_req) begin
                    if (e_en) exp_out[d * 1000000 + cyc + lat[d]] = (pr - (k - 1)) * 256 + (pc - (k - 1));
                    m_pix[d]++;
                    if (m_pix[d] == n * n) begin
                        m_run[d]  = 1'b0;
                        m_done[d] = cyc + lat[d] + 1;
                    end
                end
                if (!e_busy && s) begin
                    m_run[d] = 1'b1;
                    m_pix[d] = 0;
                end
            end
        end
        if (r) exp_out.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: clean; 1: 3-cycle stall at addr 200 plus stray starts; 2: start held for back-to-back;
    // 3: random stall/start; 4: reset mid-frame at start+300.
    task automatic run_until_idle(input int mode, input int fs);
        int guard = 0;
        int stall_cnt = 0;
        while ((m_run[0] || m_done[0] >= cyc || (mode == 2 && cyc <= fs + 788)) && guard < 2000) begin
            logic r, s, st;
            r = 1'b0; s = 1'b0; st = 1'b0;
            case (mode)
                1: begin
                    st = m_run[0] && (m_pix[0] == 200) && (stall_cnt < 3);
                    if (st) stall_cnt++;
                    s = (cyc == fs + 50) || (cyc == m_done[0]);
                end
                2: s = (cyc <= fs + 788);
                3: begin
                    st = ($urandom_range(0, 3) == 0);
                    s  = ($urandom_range(0, 15) == 0);
                end
                4: r = (cyc == fs + 300);
                default: ;
            endcase
            run_cycle(r, s, st);
            guard++;
        end
        check("frame_within_bound", 32'(guard < 2000), 32'd1);
    endtask

    task automatic check_frame(input int fs, input int extra, input int frames);
        int ofs;
        ofs = extra + (frames - 1) * 788;
        check("req_count",     cnt_req,       784 * frames);
        check("en_count",      cnt_en,        576 * frames);
        check("ov_count",      cnt_ov,        576 * frames);
        check("done_count",    cnt_done,      frames);
        check("first_en_cyc",  first_en_cyc,  fs + 117);
        check("first_en_addr", first_en_addr, 116);
        check("first_ov_cyc",  first_ov_cyc,  fs + 119);
        check("first_ov_rc",   first_ov_rc,   0);
        check("last_ov_cyc",   last_ov_cyc,   fs + 786 + ofs);
        check("last_ov_rc",    last_ov_rc,    23 * 256 + 23);
        check("done_cyc",      done_cyc,      fs + 787 + ofs);
    endtask

    initial begin
        int fs;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        clear_tallies();
        repeat (2) @(posedge clk);
        #1;
        run_cycle(1'b1, 1'b0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0, 1'b1);

        // Clean frame on both instances.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(0, fs);
        check_frame(fs, 0, 1);
        check("d1_en_count", d1_en_cnt,   1);
        check("d1_en_cyc",   d1_en_cyc,   fs + 16);
        check("d1_en_addr",  d1_en_addr,  15);
        check("d1_ov_cyc",   d1_ov_cyc,   fs + 17);
        check("d1_ov_rc",    d1_ov_rc,    0);
        check("d1_done_cyc", d1_done_cyc, fs + 18);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0);

        // Stall while addr 200 pending, stray starts during RUN and DONE.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(1, fs);
        check_frame(fs, 3, 1);
        repeat (5) run_cycle(1'b0, 1'b0, 1'b0);

        // Reset mid-frame: nothing in flight may surface afterwards.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(4, fs);
        clear_tallies();
        repeat (30) run_cycle(1'b0, 1'b0, 1'b0);
        check("post_rst_ov",   cnt_ov,   0);
        check("post_rst_done", cnt_done, 0);

        // Clean frame after the aborted one.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(0, fs);
        check_frame(fs, 0, 1);
        repeat (2) run_cycle(1'b0, 1'b0, 1'b0);

        // Back-to-back frames with start held high.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(2, fs);
        check_frame(fs, 0, 2);
        repeat (2) run_cycle(1'b0, 1'b0, 1'b0);

        // Random stalls and start noise.
        clear_tallies();
        fs = cyc;
        run_cycle(1'b0, 1'b1, 1'b0);
        run_until_idle(3, fs);
        check("rand_req_count",  cnt_req,  784);
        check("rand_ov_count",   cnt_ov,   576);
        check("rand_done_count", cnt_done, 1);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
